// File: rtl/trace_ctrl_pkg.sv
// trace_ctrl_pkg: controller state encoding shared by the capture/readout RTL
package trace_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, CAPTURE, RD_ADDR, RD_WAIT, RD_HOLD} tc_state_t;
endpackage

// File: rtl/tb_ptr_tracker.sv
// tb_ptr_tracker: newest-entry pointer, saturating entry count and oldest-entry pointer
module tb_ptr_tracker #(
    parameter int TB_SIZE = 8,
    localparam int TB_ADDR = $clog2(TB_SIZE)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               advance,
    output logic [TB_ADDR-1:0] cur_ptr,
    output logic [TB_ADDR:0]   entries,
    output logic [TB_ADDR-1:0] oldest
);
    localparam logic [TB_ADDR:0] FULL = (TB_ADDR + 1)'(TB_SIZE);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cur_ptr <= '1;
            entries <= '0;
        end else if (advance) begin
            cur_ptr <= cur_ptr + 1'b1;
            entries <= (entries == FULL) ? entries : entries + 1'b1;
        end
    end
    // once the buffer has wrapped, the slot after the newest is the oldest
    assign oldest = (entries == FULL) ? cur_ptr + 1'b1 : '0;
endmodule

// File: rtl/trace_capture_controller.sv
// trace_capture_controller: captures compressor beats into a trace RAM and replays them oldest-first
module trace_capture_controller
    import trace_ctrl_pkg::*;
#(
    parameter int N = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE = 8,
    localparam int TB_ADDR = $clog2(TB_SIZE),
    localparam int W = DATA_WIDTH * N
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_capture,
    input  logic               stop_capture,
    input  logic               start_readout,
    output logic               comp_tracing,
    input  logic               c_valid,
    input  logic               c_comp,
    input  logic               c_inc_tb_ptr,
    input  logic [W-1:0]       c_vector,
    output logic               tb_we,
    output logic [TB_ADDR-1:0] tb_addr,
    output logic [W-1:0]       tb_wdata,
    input  logic [W-1:0]       tb_rdata,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [W-1:0]       rd_data,
    output logic               rd_comp,
    output logic               rd_last,
    output logic [TB_ADDR:0]   entries,
    output logic               busy
);
    typedef logic [TB_ADDR-1:0] tc_ptr_t;
    tc_state_t state, state_next;
    tc_ptr_t cur_ptr, oldest, rd_ptr, wr_ptr;
    logic [TB_SIZE-1:0] flags;
    logic clear, advance, beat, hs;

    assign clear = state == IDLE && start_capture;
    assign advance = state == CAPTURE && c_valid && c_inc_tb_ptr;
    // a non-advancing beat refines the newest entry, so it needs one to exist
    assign beat = state == CAPTURE && c_valid && (c_inc_tb_ptr || entries != '0);
    assign wr_ptr = c_inc_tb_ptr ? cur_ptr + 1'b1 : cur_ptr;
    assign hs = state == RD_HOLD && rd_ready;

    tb_ptr_tracker #(.TB_SIZE(TB_SIZE)) u_ptr (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .advance(advance),
        .cur_ptr(cur_ptr),
        .entries(entries),
        .oldest(oldest)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start_capture ? CAPTURE : (start_readout && entries != '0) ? RD_ADDR : IDLE;
            CAPTURE: state_next = stop_capture ? IDLE : CAPTURE;
            RD_ADDR: state_next = RD_WAIT;
            RD_WAIT: state_next = RD_HOLD;
            RD_HOLD: state_next = !rd_ready ? RD_HOLD : rd_last ? IDLE : RD_ADDR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            comp_tracing <= 1'b1;
            busy <= 1'b0;
            rd_valid <= 1'b0;
            tb_we <= 1'b0;
            tb_addr <= '0;
            tb_wdata <= '0;
            rd_data <= '0;
            rd_comp <= 1'b0;
            rd_last <= 1'b0;
            rd_ptr <= '0;
            flags <= '0;
        end else begin
            comp_tracing <= state_next != CAPTURE;
            busy <= state_next != IDLE;
            rd_valid <= state_next == RD_HOLD;
            tb_we <= beat;
            if (clear) flags <= '0;
            if (beat) begin
                tb_addr <= wr_ptr;
                tb_wdata <= c_vector;
                flags[wr_ptr] <= c_comp;
            end
            if (state == IDLE && state_next == RD_ADDR) begin
                rd_ptr <= oldest;
                tb_addr <= oldest;
            end
            // the newest entry is always the final one replayed
            if (state == RD_WAIT) begin
                rd_data <= tb_rdata;
                rd_comp <= flags[rd_ptr];
                rd_last <= rd_ptr == cur_ptr;
            end
            if (hs) begin
                rd_last <= 1'b0;
                if (!rd_last) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    tb_addr <= rd_ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_trace_capture_controller.sv
// tb_trace_capture_controller: randomized checks against a queue model of the captured trace
module tb_trace_capture_controller;
    logic clk = 1'b0;
    logic reset, start_capture, stop_capture, start_readout;
    logic c_valid, c_comp, c_inc_tb_ptr, rd_ready;
    logic [15:0] c_vector, tb_wdata, tb_rdata, rd_data;
    logic comp_tracing, tb_we, rd_valid, rd_comp, rd_last, busy;
    logic [1:0] tb_addr;
    logic [2:0] entries;
    logic [15:0] mem [4];
    typedef struct packed {logic [15:0] d; logic c;} ent_t;
    ent_t q[$];
    int incs, total, bad;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) mem[tb_addr] <= tb_wdata;
        tb_rdata <= mem[tb_addr];
    end

    trace_capture_controller #(.N(2), .DATA_WIDTH(8), .TB_SIZE(4)) dut (
        .clk(clk), .reset(reset), .start_capture(start_capture), .stop_capture(stop_capture),
        .start_readout(start_readout), .comp_tracing(comp_tracing), .c_valid(c_valid),
        .c_comp(c_comp), .c_inc_tb_ptr(c_inc_tb_ptr), .c_vector(c_vector), .tb_we(tb_we),
        .tb_addr(tb_addr), .tb_wdata(tb_wdata), .tb_rdata(tb_rdata), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_comp(rd_comp), .rd_last(rd_last),
        .entries(entries), .busy(busy)
    );

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        q.delete();
        incs = 0;
    endtask

    task automatic start_cap();
        start_capture = 1'b1;
        @(negedge clk);
        start_capture = 1'b0;
        q.delete();
        incs = 0;
        total++;
        if (comp_tracing !== 1'b0 || busy !== 1'b1 || entries !== 3'd0) begin
            bad++;
            $display("FAIL start_cap: tracing=%b busy=%b entries=%0d want 0 1 0", comp_tracing, busy, entries);
        end
    endtask

    task automatic beat(input logic v, input logic inc, input logic cp, input logic [15:0] d, input logic st);
        logic exp_we;
        logic [1:0] exp_addr;
        c_valid = v; c_inc_tb_ptr = inc; c_comp = cp; c_vector = d; stop_capture = st;
        exp_we = 1'b0;
        if (v && inc) begin
            q.push_back('{d, cp});
            if (q.size() > 4) void'(q.pop_front());
            incs++;
            exp_we = 1'b1;
        end else if (v && q.size() > 0) begin
            q[q.size()-1] = '{d, cp};
            exp_we = 1'b1;
        end
        exp_addr = 2'((incs + 3) % 4);
        @(negedge clk);
        c_valid = 1'b0; stop_capture = 1'b0;
        total++;
        if (tb_we !== exp_we) begin
            bad++;
            $display("FAIL write_en: got=%b want=%b", tb_we, exp_we);
        end
        if (exp_we) begin
            total++;
            if (tb_addr !== exp_addr || tb_wdata !== d) begin
                bad++;
                $display("FAIL write: addr=%0d data=%h want addr=%0d data=%h", tb_addr, tb_wdata, exp_addr, d);
            end
        end
        if (st) begin
            total++;
            if (busy !== 1'b0 || comp_tracing !== 1'b1 || entries !== 3'(q.size())) begin
                bad++;
                $display("FAIL stop: busy=%b tracing=%b entries=%0d want 0 1 %0d", busy, comp_tracing, entries, q.size());
            end
        end
    endtask

    // mode 0: always ready, 1: five stalled hold cycles on first entry, 2: random ready
    task automatic readout(input int mode);
        int idx, hold, n;
        logic r;
        idx = 0; hold = 0; n = q.size();
        start_readout = 1'b1;
        @(negedge clk);
        start_readout = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL readout_start: busy=%b want 1", busy);
        end
        for (int cyc = 0; cyc < 200 && idx < n; cyc++) begin
            if (rd_valid) begin
                total++;
                if (rd_data !== q[idx].d || rd_comp !== q[idx].c || rd_last !== (idx == n - 1)) begin
                    bad++;
                    $display("FAIL rd_entry%0d: data=%h comp=%b last=%b want %h %b %b",
                             idx, rd_data, rd_comp, rd_last, q[idx].d, q[idx].c, idx == n - 1);
                end
                if (idx == 0) hold++;
            end
            r = (mode == 0) ? 1'b1 : (mode == 1) ? (idx > 0 || hold >= 6) : ($urandom_range(0, 2) != 0);
            if (rd_valid && r) idx++;
            rd_ready = r;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        total++;
        if (idx != n || rd_valid !== 1'b0 || busy !== 1'b0 || entries !== 3'(n)) begin
            bad++;
            $display("FAIL readout_end: read=%0d valid=%b busy=%b entries=%0d want %0d 0 0 %0d", idx, rd_valid, busy, entries, n, n);
        end
        if (mode == 1) begin
            total++;
            if (hold != 6) begin
                bad++;
                $display("FAIL backpressure: hold cycles=%0d want 6", hold);
            end
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if (comp_tracing !== 1'b1 || tb_we !== 1'b0 || rd_valid !== 1'b0 || entries !== 3'd0 || busy !== 1'b0
            || tb_addr !== 2'd0 || rd_data !== 16'd0 || rd_last !== 1'b0 || rd_comp !== 1'b0) begin
            bad++;
            $display("FAIL reset: tracing=%b we=%b valid=%b entries=%0d busy=%b addr=%0d", comp_tracing, tb_we, rd_valid, entries, busy, tb_addr);
        end
    endtask

    task automatic test_capture_fill();
        start_cap();
        beat(1, 1, 1, 16'hA0A1, 0);
        beat(1, 0, 1, 16'hB0B1, 0);
        beat(1, 0, 1, 16'hC0C1, 0);
        beat(1, 1, 0, 16'hD0D1, 1);
        readout(0);
    endtask

    task automatic test_wrap();
        start_cap();
        for (int i = 0; i < 6; i++) beat(1, 1, 1'($urandom_range(0, 1)), 16'($urandom), i == 5);
        readout(0);
    endtask

    task automatic test_backpressure();
        readout(1);
    endtask

    task automatic test_ignored();
        do_reset(1);
        start_readout = 1'b1; c_valid = 1'b1; c_inc_tb_ptr = 1'b1;
        @(negedge clk);
        start_readout = 1'b0; c_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_valid !== 1'b0 || tb_we !== 1'b0 || entries !== 3'd0) begin
            bad++;
            $display("FAIL empty_readout: busy=%b valid=%b we=%b entries=%0d", busy, rd_valid, tb_we, entries);
        end
        start_cap();
        beat(1, 0, 1, 16'h1111, 0);
        start_readout = 1'b1;
        @(negedge clk);
        start_readout = 1'b0;
        total++;
        if (comp_tracing !== 1'b0 || busy !== 1'b1 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL readout_in_capture: tracing=%b busy=%b valid=%b want 0 1 0", comp_tracing, busy, rd_valid);
        end
        beat(1, 1, 0, 16'h2222, 1);
        start_capture = 1'b1; start_readout = 1'b1;
        @(negedge clk);
        start_capture = 1'b0; start_readout = 1'b0;
        q.delete();
        incs = 0;
        total++;
        if (comp_tracing !== 1'b0 || entries !== 3'd0 || rd_valid !== 1'b0) begin
            bad++;
            $display("FAIL simultaneous_start: tracing=%b entries=%0d valid=%b want 0 0 0", comp_tracing, entries, rd_valid);
        end
        beat(1, 1, 1, 16'h3333, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || entries !== 3'd0 || comp_tracing !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_capture: valid=%b busy=%b entries=%0d tracing=%b", rd_valid, busy, entries, comp_tracing);
        end
    endtask

    task automatic test_reset_in_hold();
        int waited;
        start_cap();
        beat(1, 1, 0, 16'h4444, 0);
        beat(1, 1, 1, 16'h5555, 1);
        start_readout = 1'b1;
        @(negedge clk);
        start_readout = 1'b0;
        waited = 0;
        while (rd_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (rd_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_timeout: rd_valid=%b after %0d cycles", rd_valid, waited);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        incs = 0;
        total++;
        if (rd_valid !== 1'b0 || busy !== 1'b0 || entries !== 3'd0 || comp_tracing !== 1'b1 || rd_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_readout: valid=%b busy=%b entries=%0d tracing=%b last=%b", rd_valid, busy, entries, comp_tracing, rd_last);
        end
    endtask

    task automatic test_random();
        int n;
        for (int s = 0; s < 8; s++) begin
            start_cap();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                beat($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), i == n - 1);
            if (q.size() > 0) begin
                readout(2);
                readout(0);
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; incs = 0;
        reset = 1'b0; start_capture = 1'b0; stop_capture = 1'b0; start_readout = 1'b0;
        c_valid = 1'b0; c_comp = 1'b0; c_inc_tb_ptr = 1'b0; c_vector = '0; rd_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_capture_fill();
        test_wrap();
        test_backpressure();
        test_ignored();
        test_reset_in_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
